// File: rtl/matrix_key_scanner_if.sv
// Key-matrix pins and decoded key outputs of matrix_key_scanner.
// master = scanner side, slave = matrix/consumer side.
interface matrix_key_scanner_if;
  logic [3:0] row_in;
  logic [3:0] col_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_down;

  modport master (input row_in, output col_out, key_code, key_valid, key_down);
  modport slave  (output row_in, input col_out, key_code, key_valid, key_down);
endinterface

// File: rtl/matrix_key_scanner.sv
// 4x4 key-matrix scanner with whole-frame debounce and single-key decode.
// Optional auto-repeat of the held key when KEY_REPEAT_EN is defined.
module matrix_key_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_DELAY   = 32,
  parameter int REPEAT_RATE    = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  matrix_key_scanner_if.master kbd
);
  localparam int DW = $clog2(SCAN_DIV);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [SW-1:0] STAB_MAX = SW'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {RES_NONE, RES_SINGLE, RES_MULTI} res_e;
  typedef enum logic {IDLE, PRESSED} state_e;

  logic [3:0]    row_meta, row_sync;
  logic [DW-1:0] div_cnt;
  logic [1:0]    slot;
  logic          slot_end, frame_end;
  // hit counts saturate at 2, meaning "two or more"
  logic [1:0]    acc_hits, slot_hits, tot_hits;
  logic [3:0]    acc_code, slot_code, tot_code;
  res_e          res_kind, prev_kind;
  logic [3:0]    res_code, prev_code;
  logic [SW-1:0] stab_cnt, stab_next;
  state_e        state, state_d;
  logic          accept, rep_fire, pulse_d;
  logic [3:0]    key_code_r;
  logic          key_valid_r;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta <= 4'hF;
      row_sync <= 4'hF;
    end else begin
      row_meta <= kbd.row_in;
      row_sync <= row_meta;
    end
  end

  assign slot_end  = (div_cnt == DW'(SCAN_DIV - 1));
  assign frame_end = slot_end && (slot == 2'd3);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      slot    <= 2'd0;
    end else if (slot_end) begin
      div_cnt <= '0;
      slot    <= slot + 2'd1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Fold the current slot's rows into the running frame tally
  always_comb begin
    slot_hits = 2'd0;
    slot_code = 4'd0;
    for (int r = 0; r < 4; r++) begin
      if (!row_sync[r]) begin
        slot_hits = (slot_hits == 2'd0) ? 2'd1 : 2'd2;
        slot_code = {2'(r), slot};
      end
    end
    if (acc_hits == 2'd0) begin
      tot_hits = slot_hits;
      tot_code = slot_code;
    end else begin
      tot_hits = (slot_hits == 2'd0) ? acc_hits : 2'd2;
      tot_code = acc_code;
    end
  end

  // NONE/MULTI carry code 0 so a plain compare covers "same result"
  always_comb begin
    res_kind = RES_MULTI;
    res_code = 4'd0;
    if (tot_hits == 2'd0) begin
      res_kind = RES_NONE;
    end else if (tot_hits == 2'd1) begin
      res_kind = RES_SINGLE;
      res_code = tot_code;
    end
    if ((res_kind == prev_kind) && (res_code == prev_code))
      stab_next = (stab_cnt == STAB_MAX) ? STAB_MAX : stab_cnt + 1'b1;
    else
      stab_next = SW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_hits  <= 2'd0;
      acc_code  <= 4'd0;
      prev_kind <= RES_NONE;
      prev_code <= 4'd0;
      stab_cnt  <= '0;
    end else if (slot_end) begin
      if (frame_end) begin
        acc_hits  <= 2'd0;
        acc_code  <= 4'd0;
        prev_kind <= res_kind;
        prev_code <= res_code;
        stab_cnt  <= stab_next;
      end else begin
        acc_hits <= tot_hits;
        acc_code <= tot_code;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (frame_end && (stab_next == STAB_MAX)) begin
      case (state)
        IDLE:    if (res_kind == RES_SINGLE) state_d = PRESSED;
        PRESSED: if (res_kind == RES_NONE)   state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    accept  = frame_end && (state == IDLE) && (state_d == PRESSED);
    pulse_d = accept || rep_fire;
  end

`ifdef KEY_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);

  logic [RW-1:0] rep_cnt, rep_thr;
  logic          rep_first, rep_match;

  assign rep_match = (state == PRESSED) && (state_d == PRESSED) &&
                     (res_kind == RES_SINGLE) && (res_code == key_code_r);
  assign rep_thr   = rep_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_RATE);
  assign rep_fire  = frame_end && rep_match && ((rep_cnt + 1'b1) == rep_thr);

  // rep_first selects the initial delay; any non-matching frame rearms it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (state != PRESSED) begin
      rep_cnt   <= '0;
      rep_first <= 1'b1;
    end else if (frame_end) begin
      if (rep_fire) begin
        rep_cnt   <= '0;
        rep_first <= 1'b0;
      end else if (rep_match) begin
        rep_cnt <= rep_cnt + 1'b1;
      end else begin
        rep_cnt   <= '0;
        rep_first <= 1'b1;
      end
    end
  end
`else
  assign rep_fire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_valid_r <= 1'b0;
      key_code_r  <= 4'd0;
    end else begin
      key_valid_r <= pulse_d;
      if (accept) key_code_r <= res_code;
    end
  end

  assign kbd.col_out   = ~(4'b0001 << slot);
  assign kbd.key_code  = key_code_r;
  assign kbd.key_valid = key_valid_r;
  assign kbd.key_down  = (state == PRESSED);
endmodule

// File: tb/tb_matrix_key_scanner.sv
// Scoreboard bench: a frame-level key model predicts press/release events,
// a negedge monitor checks column strobes and every event the DUT emits.
module tb_matrix_key_scanner;
  localparam int SD = 4;
  localparam int DB = 3;
  localparam int RD = 2;
  localparam int RR = 1;
  localparam int FRAME = 4 * SD;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [15:0] keys = 16'h0;
  logic [3:0]  rows;
  int cyc;
  int checks = 0;
  int errors = 0;

  typedef struct {bit rel; logic [3:0] code; int stamp;} ev_t;
  ev_t exp_q[$];

  matrix_key_scanner_if kbd();

  matrix_key_scanner #(
    .SCAN_DIV(SD), .DEBOUNCE_SCANS(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .kbd(kbd)
  );

  always #5 clk = ~clk;

  // Passive matrix: a pressed key pulls its row low while its column is strobed
  always_comb begin
    rows = 4'hF;
    for (int k = 0; k < 16; k++)
      if (keys[k] && !kbd.col_out[k % 4]) rows[k / 4] = 1'b0;
  end
  assign kbd.row_in = rows;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Reference model, one call per frame
  int m_kind, m_pcode, m_run, m_code, m_rep, fcnt;
  bit m_down, m_first;

  task automatic model_reset();
    m_kind = 0; m_pcode = 0; m_run = 0; m_down = 0;
    m_code = 0; m_rep = 0; m_first = 1; fcnt = 0;
  endtask

  task automatic model_frame(input logic [15:0] k);
    int n, kind, code, stamp;
    ev_t e;
    n = $countones(k);
    kind = (n == 0) ? 0 : ((n == 1) ? 1 : 2);
    code = 0;
    if (kind == 1)
      for (int i = 0; i < 16; i++) if (k[i]) code = i;
    if (kind == m_kind && code == m_pcode) m_run = (m_run >= DB) ? DB : m_run + 1;
    else m_run = 1;
    m_kind = kind; m_pcode = code;
    stamp = (fcnt + 1) * FRAME;
    if (!m_down) begin
      if (m_run == DB && kind == 1) begin
        e.rel = 0; e.code = 4'(code); e.stamp = stamp; exp_q.push_back(e);
        m_down = 1; m_code = code; m_rep = 0; m_first = 1;
      end
    end else if (m_run == DB && kind == 0) begin
      e.rel = 1; e.code = 4'(m_code); e.stamp = stamp; exp_q.push_back(e);
      m_down = 0;
    end else begin
`ifdef KEY_REPEAT_EN
      if (kind == 1 && code == m_code) begin
        m_rep++;
        if (m_rep == (m_first ? RD : RR)) begin
          e.rel = 0; e.code = 4'(m_code); e.stamp = stamp; exp_q.push_back(e);
          m_rep = 0; m_first = 0;
        end
      end else begin
        m_rep = 0; m_first = 1;
      end
`endif
    end
    fcnt++;
  endtask

  task automatic do_frames(input logic [15:0] k, input int n);
    for (int i = 0; i < n; i++) begin
      keys = k;
      model_frame(k);
      repeat (FRAME) @(negedge clk);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    checks++;
    if (kbd.col_out !== 4'b1110 || kbd.key_code !== 4'h0 ||
        kbd.key_valid !== 1'b0 || kbd.key_down !== 1'b0) begin
      errors++;
      $display("FAIL %s: col=%b code=%h valid=%b down=%b, required col=1110 code=0 valid=0 down=0",
               tag, kbd.col_out, kbd.key_code, kbd.key_valid, kbd.key_down);
    end
  endtask

  // Monitor
  bit prev_down = 0;
  always @(negedge clk) begin
    logic [3:0] exp_col;
    ev_t e;
    if (!rst_n) begin
      prev_down = 0;
    end else begin
      exp_col = ~(4'b0001 << ((cyc / SD) % 4));
      checks++;
      if (kbd.col_out !== exp_col) begin
        errors++;
        $display("FAIL col_out cyc=%0d: got %b, required %b", cyc, kbd.col_out, exp_col);
      end
      if (kbd.key_valid === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL press: unexpected key_valid code=%h cyc=%0d", kbd.key_code, cyc);
        end else begin
          e = exp_q.pop_front();
          if (e.rel || e.code !== kbd.key_code || e.stamp != cyc || kbd.key_down !== 1'b1) begin
            errors++;
            $display("FAIL press: got code=%h cyc=%0d down=%b, required rel=%0d code=%h cyc=%0d down=1",
                     kbd.key_code, cyc, kbd.key_down, e.rel, e.code, e.stamp);
          end
        end
      end
      if (prev_down && kbd.key_down !== 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL release: unexpected key_down fall cyc=%0d", cyc);
        end else begin
          e = exp_q.pop_front();
          if (!e.rel || e.stamp != cyc || kbd.key_code !== e.code) begin
            errors++;
            $display("FAIL release: got cyc=%0d code=%h, required rel=%0d cyc=%0d code=%h",
                     cyc, kbd.key_code, e.rel, e.stamp, e.code);
          end
        end
      end
      if (!prev_down && kbd.key_down === 1'b1 && kbd.key_valid !== 1'b1) begin
        checks++;
        errors++;
        $display("FAIL down_rise: key_down rose without key_valid cyc=%0d", cyc);
      end
      prev_down = (kbd.key_down === 1'b1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, queue=%0d", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, a, b, len;
    model_reset();
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;

    do_frames(16'h0000, 3);                      // idle
    do_frames(16'h0200, 5);                      // key 9 clean
    do_frames(16'h0000, 4);
    for (int i = 0; i < 2; i++) begin            // key 3 bounce
      do_frames(16'h0008, 1);
      do_frames(16'h0000, 1);
    end
    do_frames(16'h0008, 4);
    do_frames(16'h0000, 4);
    do_frames(16'h0060, 4);                      // keys 5+6 together
    do_frames(16'h0000, 2);
    do_frames(16'h0020, 4);                      // press 5, add 6, release
    do_frames(16'h0060, 4);
    do_frames(16'h0000, 4);
    do_frames(16'h0020, 4);                      // press 5, switch to 6
    do_frames(16'h0040, 4);
    do_frames(16'h0000, 4);
    do_frames(16'h8000, 8);                      // hold F (repeat when enabled)
    do_frames(16'h0000, 4);

    for (int i = 0; i < 40; i++) begin
      kind = $urandom_range(0, 2);
      a = $urandom_range(0, 15);
      b = (a + $urandom_range(1, 15)) % 16;
      len = $urandom_range(1, 5);
      case (kind)
        0: do_frames(16'h0000, len);
        1: do_frames(16'(1) << a, len);
        default: do_frames((16'(1) << a) | (16'(1) << b), len);
      endcase
    end
    do_frames(16'h0000, 4);

    // Reset mid slot 2 while a key is down
    do_frames(16'h0400, 3);
    repeat (2 * SD + 1) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL pending_before_reset: got %0d events, required 0", exp_q.size());
      exp_q.delete();
    end
    model_reset();
    keys = 16'h0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset_hold");
    rst_n = 1'b1;
    do_frames(16'h0000, 1);
    do_frames(16'h0100, 4);
    do_frames(16'h0000, 4);

    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL missing_events: got %0d unmatched, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
